// File: rtl/mem_access_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_bridge_pkg
//  Purpose  : Shared types and codes for the CPU/MMU/bus access bridge:
//             access type, MMU exception type, FSM state encoding and the
//             response exception codes.
//  Revision : 1.0  initial release
// ============================================================================
package mem_access_bridge_pkg;

    // Access direction; write is the asserted value.
    typedef enum logic {
        MEM_ACCESS_R = 1'b0,
        MEM_ACCESS_W = 1'b1
    } mem_access_t;

    // Exception reported by the MMU in the cycle after a lookup.
    typedef enum logic [1:0] {
        MMU_EXC_NONE         = 2'd0,
        MMU_EXC_TLB_MISS     = 2'd1,
        MMU_EXC_TLB_INVALID  = 2'd2,
        MMU_EXC_TLB_MODIFIED = 2'd3
    } mmu_exception_t;

    // Bridge sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_BUS   = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Response exception codes.
    localparam logic [2:0] c_EXC_NONE         = 3'd0;
    localparam logic [2:0] c_EXC_TLB_MISS     = 3'd1;
    localparam logic [2:0] c_EXC_TLB_INVALID  = 3'd2;
    localparam logic [2:0] c_EXC_TLB_MODIFIED = 3'd3;
    localparam logic [2:0] c_EXC_ADDR         = 3'd4;
    localparam logic [2:0] c_EXC_BUS          = 3'd5;

    // Access size codes.
    localparam logic [1:0] c_SIZE_BYTE = 2'd0;
    localparam logic [1:0] c_SIZE_HALF = 2'd1;
    localparam logic [1:0] c_SIZE_WORD = 2'd2;

    // Upper address bits selecting the unmapped kseg0/kseg1 window.
    localparam logic [1:0] c_KSEG_PREFIX = 2'b10;

    // Translate an MMU exception into the response exception code.
    function automatic logic [2:0] mmu_exc_to_resp(input mmu_exception_t e);
        logic [2:0] code;
        code = c_EXC_NONE;
        case (e)
            MMU_EXC_TLB_MISS:     code = c_EXC_TLB_MISS;
            MMU_EXC_TLB_INVALID:  code = c_EXC_TLB_INVALID;
            MMU_EXC_TLB_MODIFIED: code = c_EXC_TLB_MODIFIED;
            default:              code = c_EXC_NONE;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_align_check.sv
`default_nettype none
// ============================================================================
//  Module   : mem_align_check
//  Purpose  : Byte-lane enable generation and natural-alignment check for an
//             access of the given size at the given low address bits.
//  Revision : 1.0  initial release
// ============================================================================
module mem_align_check
    import mem_access_bridge_pkg::*;
(
    input  logic [1:0] i_size,
    input  logic [1:0] i_addr_lo,
    output logic [3:0] o_be,
    output logic       o_misaligned
);

    // Lane enables follow the low address bits; reserved size is always a fault.
    always_comb begin
        o_be         = 4'b0000;
        o_misaligned = 1'b0;
        case (i_size)
            c_SIZE_BYTE: begin
                o_be = 4'b0001 << i_addr_lo;
            end
            c_SIZE_HALF: begin
                o_be         = 4'b0011 << i_addr_lo;
                o_misaligned = i_addr_lo[0];
            end
            c_SIZE_WORD: begin
                o_be         = 4'b1111;
                o_misaligned = (i_addr_lo != 2'b00);
            end
            default: begin
                o_misaligned = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_bridge
//  Purpose  : Single-outstanding CPU memory access bridge. Checks alignment,
//             translates through the MMU (or bypasses it for kseg0/1),
//             performs one bus transfer with timeout and returns a one-cycle
//             response with exception code.
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_bridge
    import mem_access_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic           clk,
    input  logic           res,
    // CPU side
    input  logic           cpu_req,
    output logic           cpu_ready,
    input  logic [31:0]    cpu_vaddr,
    input  mem_access_t    cpu_access,
    input  logic [1:0]     cpu_size,
    input  logic [31:0]    cpu_wdata,
    output logic           resp_valid,
    output logic [31:0]    resp_rdata,
    output logic [2:0]     resp_exc,
    output logic [31:0]    resp_badvaddr,
    // MMU side
    output logic           addrValid,
    output logic [31:0]    vAddrIn,
    output mem_access_t    mmu_accessType,
    input  logic [31:0]    pAddrOut,
    input  mmu_exception_t mmu_exception,
    // Bus side
    output logic           bus_req,
    output logic [31:0]    bus_addr,
    output logic           bus_we,
    output logic [3:0]     bus_be,
    output logic [31:0]    bus_wdata,
    input  logic [31:0]    bus_rdata,
    input  logic           bus_ack
);

    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT_CYCLES);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_vaddr;
    logic [31:0] r_paddr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [31:0] r_badvaddr;
    mem_access_t r_access;
    logic [1:0]  r_size;
    logic [2:0]  r_exc;
    logic [15:0] r_cnt;

    logic        w_accept;
    logic        w_kseg;
    logic [1:0]  w_al_size;
    logic [1:0]  w_al_addr;
    logic [3:0]  w_be;
    logic        w_misaligned;
    logic [15:0] w_cnt_inc;
    logic        w_timeout;
    logic        w_mmu_fault;

    assign w_accept    = (r_state == ST_IDLE) && cpu_req;
    assign w_kseg      = (cpu_vaddr[31:30] == c_KSEG_PREFIX);
    assign w_cnt_inc   = r_cnt + 16'd1;
    assign w_timeout   = (w_cnt_inc == c_TIMEOUT);
    assign w_mmu_fault = (mmu_exception != MMU_EXC_NONE);

    // The checker sees the incoming request while idle and the latched
    // physical address afterwards, so one instance serves both uses.
    assign w_al_size = (r_state == ST_IDLE) ? cpu_size         : r_size;
    assign w_al_addr = (r_state == ST_IDLE) ? cpu_vaddr[1:0]   : r_paddr[1:0];

    mem_align_check u_align (
        .i_size       (w_al_size),
        .i_addr_lo    (w_al_addr),
        .o_be         (w_be),
        .o_misaligned (w_misaligned)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state selection.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cpu_req) begin
                    if (w_misaligned) begin
                        w_state_next = ST_RESP;
                    end else if (w_kseg) begin
                        w_state_next = ST_BUS;
                    end else begin
                        w_state_next = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                w_state_next = w_mmu_fault ? ST_RESP : ST_BUS;
            end
            ST_BUS: begin
                if (bus_ack || w_timeout) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Request latching, translation capture, timeout count and response data.
    always_ff @(posedge clk) begin
        if (res) begin
            r_vaddr    <= '0;
            r_paddr    <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_badvaddr <= '0;
            r_access   <= MEM_ACCESS_R;
            r_size     <= '0;
            r_exc      <= c_EXC_NONE;
            r_cnt      <= '0;
        end else begin
            r_cnt <= (r_state == ST_BUS) ? w_cnt_inc : 16'd0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_vaddr  <= cpu_vaddr;
                        r_access <= cpu_access;
                        r_size   <= cpu_size;
                        r_wdata  <= cpu_wdata;
                        if (w_misaligned) begin
                            r_exc      <= c_EXC_ADDR;
                            r_badvaddr <= cpu_vaddr;
                            r_rdata    <= '0;
                        end else if (w_kseg) begin
                            r_paddr <= {3'b000, cpu_vaddr[28:0]};
                        end
                    end
                end
                ST_CHECK: begin
                    if (w_mmu_fault) begin
                        r_exc      <= mmu_exc_to_resp(mmu_exception);
                        r_badvaddr <= r_vaddr;
                        r_rdata    <= '0;
                    end else begin
                        r_paddr <= pAddrOut;
                    end
                end
                ST_BUS: begin
                    if (bus_ack) begin
                        r_exc      <= c_EXC_NONE;
                        r_badvaddr <= '0;
                        r_rdata    <= (r_access == MEM_ACCESS_R) ? bus_rdata : 32'd0;
                    end else if (w_timeout) begin
                        r_exc      <= c_EXC_BUS;
                        r_badvaddr <= r_vaddr;
                        r_rdata    <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs: MMU lookup is issued combinationally in the accept cycle only.
    assign cpu_ready      = (r_state == ST_IDLE);
    assign addrValid      = w_accept && !w_misaligned && !w_kseg;
    assign vAddrIn        = cpu_vaddr;
    assign mmu_accessType = cpu_access;

    assign bus_req   = (r_state == ST_BUS);
    assign bus_addr  = {r_paddr[31:2], 2'b00};
    assign bus_we    = (r_state == ST_BUS) && (r_access == MEM_ACCESS_W);
    assign bus_be    = (r_state == ST_BUS) ? w_be : 4'b0000;
    assign bus_wdata = r_wdata;

    assign resp_valid    = (r_state == ST_RESP);
    assign resp_rdata    = r_rdata;
    assign resp_exc      = r_exc;
    assign resp_badvaddr = r_badvaddr;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_bridge
//  Purpose  : Directed self-checking bench for mem_access_bridge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_bridge;
    import mem_access_bridge_pkg::*;

    logic           clk = 1'b0;
    logic           res;
    logic           cpu_req;
    logic           cpu_ready;
    logic [31:0]    cpu_vaddr;
    mem_access_t    cpu_access;
    logic [1:0]     cpu_size;
    logic [31:0]    cpu_wdata;
    logic           resp_valid;
    logic [31:0]    resp_rdata;
    logic [2:0]     resp_exc;
    logic [31:0]    resp_badvaddr;
    logic           addrValid;
    logic [31:0]    vAddrIn;
    mem_access_t    mmu_accessType;
    logic [31:0]    pAddrOut;
    mmu_exception_t mmu_exception;
    logic           bus_req;
    logic [31:0]    bus_addr;
    logic           bus_we;
    logic [3:0]     bus_be;
    logic [31:0]    bus_wdata;
    logic [31:0]    bus_rdata;
    logic           bus_ack;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .res            (res),
        .cpu_req        (cpu_req),
        .cpu_ready      (cpu_ready),
        .cpu_vaddr      (cpu_vaddr),
        .cpu_access     (cpu_access),
        .cpu_size       (cpu_size),
        .cpu_wdata      (cpu_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_exc       (resp_exc),
        .resp_badvaddr  (resp_badvaddr),
        .addrValid      (addrValid),
        .vAddrIn        (vAddrIn),
        .mmu_accessType (mmu_accessType),
        .pAddrOut       (pAddrOut),
        .mmu_exception  (mmu_exception),
        .bus_req        (bus_req),
        .bus_addr       (bus_addr),
        .bus_we         (bus_we),
        .bus_be         (bus_be),
        .bus_wdata      (bus_wdata),
        .bus_rdata      (bus_rdata),
        .bus_ack        (bus_ack)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are driven and outputs
    // sampled 1-2 time units after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        res = 1'b1; cpu_req = 1'b0; cpu_vaddr = '0; cpu_access = MEM_ACCESS_R;
        cpu_size = 2'd0; cpu_wdata = '0; pAddrOut = '0; mmu_exception = MMU_EXC_NONE;
        bus_rdata = '0; bus_ack = 1'b0;
        step(); step(); #1;
        n_tests++;
        if (cpu_ready !== 1'b1 || resp_valid !== 1'b0 || bus_req !== 1'b0 || addrValid !== 1'b0) begin
            $display("FAIL reset_ctrl: ready=%b rv=%b breq=%b av=%b required 1 0 0 0", cpu_ready, resp_valid, bus_req, addrValid);
            n_fail++;
        end
        n_tests++;
        if (resp_exc !== 3'd0 || resp_rdata !== 32'd0 || resp_badvaddr !== 32'd0 || bus_we !== 1'b0 || bus_be !== 4'd0) begin
            $display("FAIL reset_data: exc=%0d rdata=%h bad=%h we=%b be=%b required all zero", resp_exc, resp_rdata, resp_badvaddr, bus_we, bus_be);
            n_fail++;
        end
        res = 1'b0;
        step();
    endtask

    task automatic test_kseg_read();
        cpu_req = 1'b1; cpu_vaddr = 32'h8000_1000; cpu_access = MEM_ACCESS_R; cpu_size = 2'd2;
        #1;
        n_tests++;
        if (addrValid !== 1'b0) begin
            $display("FAIL kseg_no_mmu: addrValid=%b required 0", addrValid);
            n_fail++;
        end
        step();                         // accepted, now in BUS (first cycle)
        cpu_req = 1'b0; #1;
        n_tests++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h0000_1000 || bus_be !== 4'b1111 || bus_we !== 1'b0) begin
            $display("FAIL kseg_bus: req=%b addr=%h be=%b we=%b required 1 00001000 1111 0", bus_req, bus_addr, bus_be, bus_we);
            n_fail++;
        end
        step();                         // second BUS cycle: ack
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF; #1;
        n_tests++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h0000_1000) begin
            $display("FAIL kseg_bus_hold: req=%b addr=%h required 1 00001000", bus_req, bus_addr);
            n_fail++;
        end
        step();
        bus_ack = 1'b0; bus_rdata = '0; #1;
        n_tests++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD_BEEF || resp_exc !== 3'd0 || bus_req !== 1'b0) begin
            $display("FAIL kseg_resp: rv=%b rdata=%h exc=%0d breq=%b required 1 deadbeef 0 0", resp_valid, resp_rdata, resp_exc, bus_req);
            n_fail++;
        end
        step();
        n_tests++;
        if (resp_valid !== 1'b0 || cpu_ready !== 1'b1) begin
            $display("FAIL kseg_pulse: rv=%b ready=%b required 0 1", resp_valid, cpu_ready);
            n_fail++;
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs [3] = '{32'h0040_0003, 32'h8000_0002, 32'h0000_0000};
        logic [1:0]  sizes [3] = '{2'd1, 2'd2, 2'd3};
        for (int i = 0; i < 3; i++) begin
            cpu_req = 1'b1; cpu_vaddr = addrs[i]; cpu_size = sizes[i];
            cpu_access = (i == 0) ? MEM_ACCESS_W : MEM_ACCESS_R;
            #1;
            n_tests++;
            if (addrValid !== 1'b0 || bus_req !== 1'b0) begin
                $display("FAIL mis_accept[%0d]: addrValid=%b bus_req=%b required 0 0", i, addrValid, bus_req);
                n_fail++;
            end
            step();
            cpu_req = 1'b0; #1;
            n_tests++;
            if (resp_valid !== 1'b1 || resp_exc !== 3'd4 || resp_badvaddr !== addrs[i] || resp_rdata !== 32'd0 || bus_req !== 1'b0 || addrValid !== 1'b0) begin
                $display("FAIL mis_resp[%0d]: rv=%b exc=%0d bad=%h rdata=%h breq=%b av=%b required 1 4 %h 0 0 0",
                         i, resp_valid, resp_exc, resp_badvaddr, resp_rdata, bus_req, addrValid, addrs[i]);
                n_fail++;
            end
            step();
        end
    endtask

    task automatic test_mapped_write();
        pAddrOut = 32'h0123_4002; mmu_exception = MMU_EXC_NONE;
        cpu_req = 1'b1; cpu_vaddr = 32'h0040_0002; cpu_access = MEM_ACCESS_W;
        cpu_size = 2'd0; cpu_wdata = 32'h00AB_0000;
        #1;
        n_tests++;
        if (addrValid !== 1'b1 || vAddrIn !== 32'h0040_0002 || mmu_accessType !== MEM_ACCESS_W) begin
            $display("FAIL map_lookup: av=%b vaddr=%h type=%b required 1 00400002 1", addrValid, vAddrIn, mmu_accessType);
            n_fail++;
        end
        step();                         // CHECK
        cpu_req = 1'b0; #1;
        n_tests++;
        if (addrValid !== 1'b0 || bus_req !== 1'b0 || cpu_ready !== 1'b0) begin
            $display("FAIL map_check: av=%b breq=%b ready=%b required 0 0 0", addrValid, bus_req, cpu_ready);
            n_fail++;
        end
        step();                         // BUS
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF; #1;
        n_tests++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h0123_4000 || bus_be !== 4'b0100 || bus_we !== 1'b1 || bus_wdata !== 32'h00AB_0000) begin
            $display("FAIL map_bus: req=%b addr=%h be=%b we=%b wdata=%h required 1 01234000 0100 1 00ab0000",
                     bus_req, bus_addr, bus_be, bus_we, bus_wdata);
            n_fail++;
        end
        step();                         // RESP, three cycles after accept
        bus_ack = 1'b0; bus_rdata = '0; #1;
        n_tests++;
        if (resp_valid !== 1'b1 || resp_exc !== 3'd0 || resp_rdata !== 32'd0) begin
            $display("FAIL map_resp: rv=%b exc=%0d rdata=%h required 1 0 00000000", resp_valid, resp_exc, resp_rdata);
            n_fail++;
        end
        step();
    endtask

    task automatic test_mmu_fault();
        mmu_exception_t excs [3] = '{MMU_EXC_TLB_MISS, MMU_EXC_TLB_INVALID, MMU_EXC_TLB_MODIFIED};
        logic [2:0]     codes[3] = '{3'd1, 3'd2, 3'd3};
        for (int i = 0; i < 3; i++) begin
            mmu_exception = excs[i]; pAddrOut = 32'h0555_0000;
            cpu_req = 1'b1; cpu_vaddr = 32'h0001_2340 + 32'(i * 4); cpu_access = MEM_ACCESS_R; cpu_size = 2'd2;
            step();                     // CHECK
            cpu_req = 1'b0; #1;
            step();                     // RESP
            #1;
            n_tests++;
            if (resp_valid !== 1'b1 || resp_exc !== codes[i] || resp_badvaddr !== 32'h0001_2340 + 32'(i * 4) || resp_rdata !== 32'd0 || bus_req !== 1'b0) begin
                $display("FAIL mmu_fault[%0d]: rv=%b exc=%0d bad=%h rdata=%h breq=%b required 1 %0d %h 0 0",
                         i, resp_valid, resp_exc, resp_badvaddr, resp_rdata, bus_req, codes[i], 32'h0001_2340 + 32'(i * 4));
                n_fail++;
            end
            step();
        end
        mmu_exception = MMU_EXC_NONE;
    endtask

    task automatic test_timeout();
        int hi;
        hi = 0;
        cpu_req = 1'b1; cpu_vaddr = 32'h8000_0010; cpu_access = MEM_ACCESS_W; cpu_size = 2'd2;
        step();
        cpu_req = 1'b0; #1;
        for (int i = 0; i < 10; i++) begin
            if (resp_valid) break;
            if (bus_req) hi++;
            step();
            #1;
        end
        n_tests++;
        if (resp_valid !== 1'b1 || hi != 4 || resp_exc !== 3'd5 || resp_badvaddr !== 32'h8000_0010 || resp_rdata !== 32'd0) begin
            $display("FAIL timeout: rv=%b req_cycles=%0d exc=%0d bad=%h rdata=%h required 1 4 5 80000010 0",
                     resp_valid, hi, resp_exc, resp_badvaddr, resp_rdata);
            n_fail++;
        end
        step();
        // ack arriving in the last allowed cycle must win over the timeout
        cpu_req = 1'b1; cpu_vaddr = 32'h8000_0020; cpu_access = MEM_ACCESS_R; cpu_size = 2'd2;
        step();                         // BUS cycle 1
        cpu_req = 1'b0;
        step(); step();                 // BUS cycle 3
        step();                         // BUS cycle 4
        bus_ack = 1'b1; bus_rdata = 32'h1234_5678; #1;
        n_tests++;
        if (bus_req !== 1'b1) begin
            $display("FAIL ack_at_limit_req: bus_req=%b required 1", bus_req);
            n_fail++;
        end
        step();
        bus_ack = 1'b0; #1;
        n_tests++;
        if (resp_valid !== 1'b1 || resp_exc !== 3'd0 || resp_rdata !== 32'h1234_5678) begin
            $display("FAIL ack_at_limit: rv=%b exc=%0d rdata=%h required 1 0 12345678", resp_valid, resp_exc, resp_rdata);
            n_fail++;
        end
        step();
    endtask

    task automatic test_back_to_back();
        bus_ack = 1'b1; bus_rdata = 32'hA5A5_0001;
        cpu_req = 1'b1; cpu_vaddr = 32'h8000_0100; cpu_access = MEM_ACCESS_R; cpu_size = 2'd2;
        step();                         // BUS; new vaddr must not disturb the access
        cpu_vaddr = 32'h8000_0200; #1;
        n_tests++;
        if (bus_addr !== 32'h0000_0100 || cpu_ready !== 1'b0) begin
            $display("FAIL b2b_hold: addr=%h ready=%b required 00000100 0", bus_addr, cpu_ready);
            n_fail++;
        end
        step();                         // RESP
        bus_rdata = 32'hA5A5_0002; #1;
        n_tests++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'hA5A5_0001 || cpu_ready !== 1'b0) begin
            $display("FAIL b2b_resp1: rv=%b rdata=%h ready=%b required 1 a5a50001 0", resp_valid, resp_rdata, cpu_ready);
            n_fail++;
        end
        step();                         // IDLE, accepts the held request
        n_tests++;
        if (cpu_ready !== 1'b1 || resp_valid !== 1'b0) begin
            $display("FAIL b2b_idle: ready=%b rv=%b required 1 0", cpu_ready, resp_valid);
            n_fail++;
        end
        step();                         // BUS for the second request
        cpu_req = 1'b0; #1;
        n_tests++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h0000_0200) begin
            $display("FAIL b2b_bus2: req=%b addr=%h required 1 00000200", bus_req, bus_addr);
            n_fail++;
        end
        step();
        bus_ack = 1'b0; #1;
        n_tests++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'hA5A5_0002) begin
            $display("FAIL b2b_resp2: rv=%b rdata=%h required 1 a5a50002", resp_valid, resp_rdata);
            n_fail++;
        end
        step();
    endtask

    task automatic test_reset_mid_bus();
        int rv_seen;
        rv_seen = 0;
        pAddrOut = 32'h0000_8000; mmu_exception = MMU_EXC_NONE;
        cpu_req = 1'b1; cpu_vaddr = 32'h0000_3000; cpu_access = MEM_ACCESS_R; cpu_size = 2'd2;
        step();                         // CHECK
        cpu_req = 1'b0;
        step();                         // BUS
        n_tests++;
        if (bus_req !== 1'b1) begin
            $display("FAIL rst_mid_pre: bus_req=%b required 1", bus_req);
            n_fail++;
        end
        res = 1'b1;
        step();
        n_tests++;
        if (bus_req !== 1'b0 || resp_valid !== 1'b0) begin
            $display("FAIL rst_mid_drop: bus_req=%b rv=%b required 0 0", bus_req, resp_valid);
            n_fail++;
        end
        res = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (resp_valid) rv_seen++;
        end
        n_tests++;
        if (cpu_ready !== 1'b1 || rv_seen != 0) begin
            $display("FAIL rst_mid_after: ready=%b resp_pulses=%0d required 1 0", cpu_ready, rv_seen);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_kseg_read();
        test_misaligned();
        test_mapped_write();
        test_mmu_fault();
        test_timeout();
        test_back_to_back();
        test_reset_mid_bus();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_bridge.md
MEM_ACCESS_BRIDGE -- requirements
Module: mem_access_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, 255, bus cycles without bus_ack before a bus error is reported (1..65535).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port res  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cpu_req  input  1  CPU access request; qualified by cpu_ready.
REQ-005 SHALL have port cpu_ready  output  1  bridge idle and able to accept a request.
REQ-006 SHALL have port cpu_vaddr  input  32  virtual address.
REQ-007 SHALL have port cpu_access  input  `MEM_ACCESS_T  read or write (`MEM_ACCESS_W means write).
REQ-008 SHALL have port cpu_size  input  2  access size: 0 = byte, 1 = half, 2 = word; 3 is reserved.
REQ-009 SHALL have port cpu_wdata  input  32  write data, already lane-aligned.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  output  32  read data; valid only while resp_valid is high.
REQ-012 SHALL have port resp_exc  output  3  0 none, 1 TLB miss, 2 TLB invalid, 3 TLB modified, 4 address error, 5 bus error.
REQ-013 SHALL have port resp_badvaddr  output  32  faulting virtual address; valid whenever resp_exc is nonzero.
REQ-014 SHALL have MMU-side ports addrValid out 1, vAddrIn out 32, mmu_accessType out `MEM_ACCESS_T, pAddrOut in 32, mmu_exception in `MMU_EXCEPTION_T.
REQ-015 SHALL have bus ports bus_req out 1, bus_addr out 32, bus_we out 1, bus_be out 4, bus_wdata out 32, bus_rdata in 32, bus_ack in 1.

Function
REQ-016 SHALL implement the FSM states IDLE, CHECK, BUS and RESP; cpu_ready = (state == IDLE).
REQ-017 SHALL accept a request only in IDLE when cpu_req is high, and SHALL latch vaddr, access, size and wdata on that edge.
REQ-018 On accept, SHALL check alignment: a half access with vaddr[0]=1, a word access with vaddr[1:0]≠0, or size 3 -> RESP with exc=4; the MMU is not consulted in this case.
REQ-019 An aligned vaddr with [31:30]=2'b10 (kseg0/kseg1) SHALL bypass the MMU: paddr = {3'b000, vaddr[28:0]}, next state BUS.
REQ-020 Any other aligned vaddr SHALL drive addrValid=1 combinationally in the accept cycle, with vAddrIn=cpu_vaddr and mmu_accessType=cpu_access, then go to CHECK; addrValid SHALL be 0 in every other cycle.
REQ-021 In CHECK (one cycle after accept), SHALL sample pAddrOut and mmu_exception. A nonzero exception maps to exc 1/2/3 and goes to RESP; otherwise SHALL latch paddr and go to BUS.
REQ-022 In BUS, SHALL hold bus_req high with stable bus_addr={paddr[31:2],2'b00}, bus_we, bus_be and bus_wdata until bus_ack or timeout.
REQ-023 bus_be SHALL be: byte 4'b0001<<paddr[1:0]; half 4'b0011<<paddr[1:0]; word 4'b1111.
REQ-024 On bus_ack, SHALL capture bus_rdata (reads only), drop bus_req the next cycle, and go to RESP with exc=0.
REQ-025 SHALL use a 16-bit timeout counter that is cleared on BUS entry and increments every BUS cycle; at count = TIMEOUT_CYCLES with no ack it SHALL drop bus_req and go to RESP with exc=5. An ack in the same cycle as the limit wins.
REQ-026 In RESP, SHALL pulse resp_valid for exactly one cycle and then return to IDLE; a request is next accepted one cycle later.
REQ-027 resp_rdata SHALL be 0 for writes and for faults.
REQ-028 Minimum latency, accept to resp_valid: mapped access with bus_ack in the first BUS cycle = 3 cycles; alignment fault = 1 cycle.
REQ-029 cpu_req in any state other than IDLE SHALL be ignored; there is no request queueing.

Reset
REQ-030 While res is high, SHALL set state=IDLE, cpu_ready=1, resp_valid=0, resp_exc=0, resp_rdata=0, resp_badvaddr=0, bus_req=0, bus_we=0, bus_be=0, addrValid=0 and the counter to 0.
REQ-031 Reset asserted mid-operation SHALL abandon the access with no response and drop bus_req in the following cycle.

Structure
REQ-032 State encodings and the resp_exc codes SHALL live in a shared header (mmu.vh), alongside `MMU_EXCEPTION_T.
REQ-033 The byte-enable/alignment logic SHALL be one sub-module, mem_align_check (inputs size and addr[1:0]; outputs be and misaligned).

Verification
REQ-034 Word read at 0x80001000, bus_ack after 2 cycles, rdata 0xDEADBEEF -> bus_addr 0x00001000, be 4'b1111, resp_valid with rdata 0xDEADBEEF and exc 0.
REQ-035 Half write at 0x00400003 -> resp_valid 1 cycle after accept, exc 4, badvaddr 0x00400003, addrValid and bus_req never asserted.
REQ-036 Mapped byte write at 0x00400002, MMU returns pAddr 0x01234002 with no exception -> bus_addr 0x01234000, be 4'b0100, bus_we 1.
REQ-037 Mapped read where the MMU returns TLB miss -> exc 1, badvaddr equals vaddr, no bus_req.
REQ-038 With TIMEOUT_CYCLES=4 and bus_ack never asserted -> bus_req high for exactly 4 cycles, then exc 5.
REQ-039 res asserted during BUS -> bus_req low next cycle, no resp_valid, and cpu_ready 1 after reset is released.
